regfile_dump_ctrl: RTL and testbench

- Read-side sequencer for the 8-entry RiSC-16 register file: on request, it takes ownership of both asynchronous read ports (src1/src2 → out1/out2).
- It walks all register addresses two at a time and streams each value out on a valid/ready word stream with its address, for debug and trace.
- A hold_req/hold_ack pair stalls the core, so no register write lands mid-dump.
- Sits between the core's register-file read muxes and the debug/trace unit.

---
 rtl/regfile_dump_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_regfile_dump_ctrl.sv | 470 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump_ctrl.sv
// Debug read-side sequencer: stalls the core, walks the register file two
// addresses per fetch and streams each value out on a valid/ready port.
module regfile_dump_ctrl #(
    parameter int p_WORD_LEN      = 16,
    parameter int p_REG_ADDR_LEN  = 3,
    parameter int p_REG_FILE_SIZE = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      abort,
    output logic                      hold_req,
    input  logic                      hold_ack,
    output logic [p_REG_ADDR_LEN-1:0] rd_src1,
    output logic [p_REG_ADDR_LEN-1:0] rd_src2,
    input  logic [p_WORD_LEN-1:0]     rd_out1,
    input  logic [p_WORD_LEN-1:0]     rd_out2,
    output logic                      rd_sel,
    output logic                      dump_valid,
    input  logic                      dump_ready,
    output logic [p_WORD_LEN-1:0]     dump_data,
    output logic [p_REG_ADDR_LEN-1:0] dump_addr,
    output logic                      dump_last,
    output logic                      busy,
    output logic                      done,
    output logic                      aborted
);

    // One spare index bit so index+2 never wraps for a full-size register file.
    localparam int c_IW = p_REG_ADDR_LEN + 1;
    localparam logic [c_IW-1:0] c_SIZE = c_IW'(p_REG_FILE_SIZE);
    localparam logic [c_IW-1:0] c_LAST = c_IW'(p_REG_FILE_SIZE - 1);
    localparam logic [c_IW-1:0] c_ONE  = c_IW'(1);
    localparam logic [c_IW-1:0] c_TWO  = c_IW'(2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD,
        S_FETCH,
        S_SEND0,
        S_SEND1,
        S_FIN
    } state_t;

    state_t                    state_q, state_d;
    logic [c_IW-1:0]           idx_q, idx_d;
    logic [p_WORD_LEN-1:0]     buf0_q, buf0_d;
    logic [p_WORD_LEN-1:0]     buf1_q, buf1_d;
    logic                      buf1_vld_q, buf1_vld_d;
    logic                      abort_lat_q, abort_lat_d;
    logic                      hold_req_q, hold_req_d;
    logic                      rd_sel_q, rd_sel_d;
    logic [p_REG_ADDR_LEN-1:0] rd_src1_q, rd_src1_d;
    logic [p_REG_ADDR_LEN-1:0] rd_src2_q, rd_src2_d;
    logic                      dump_valid_q, dump_valid_d;
    logic [p_WORD_LEN-1:0]     dump_data_q, dump_data_d;
    logic [p_REG_ADDR_LEN-1:0] dump_addr_q, dump_addr_d;
    logic                      dump_last_q, dump_last_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      aborted_q, aborted_d;

    logic                      hs;
    logic                      abort_now;
    logic [c_IW-1:0]           nxt_q;
    logic [c_IW-1:0]           nxt_d;
    logic [c_IW-1:0]           beat_idx;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d     = state_q;
        idx_d       = idx_q;
        buf0_d      = buf0_q;
        buf1_d      = buf1_q;
        buf1_vld_d  = buf1_vld_q;
        abort_lat_d = abort_lat_q;
        done_d      = 1'b0;
        aborted_d   = 1'b0;
        hs          = dump_valid_q & dump_ready;
        abort_now   = abort | abort_lat_q;
        nxt_q       = idx_q + c_ONE;

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_HOLD;
            end
            S_HOLD: begin
                if (abort) begin
                    state_d   = S_IDLE;
                    done_d    = 1'b1;
                    aborted_d = 1'b1;
                end else if (hold_ack) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                buf0_d     = rd_out1;
                buf1_d     = rd_out2;
                buf1_vld_d = (nxt_q < c_SIZE);
                if (abort) begin
                    state_d   = S_FIN;
                    done_d    = 1'b1;
                    aborted_d = 1'b1;
                end else begin
                    state_d = S_SEND0;
                end
            end
            S_SEND0: begin
                // Once the final beat is on the wire the dump completes normally.
                if (hs) begin
                    if (!buf1_vld_q) begin
                        state_d = S_FIN;
                        done_d  = 1'b1;
                    end else if (abort_now) begin
                        state_d   = S_FIN;
                        done_d    = 1'b1;
                        aborted_d = 1'b1;
                    end else begin
                        state_d = S_SEND1;
                    end
                end else if (abort && !dump_last_q) begin
                    abort_lat_d = 1'b1;
                end
            end
            S_SEND1: begin
                if (hs) begin
                    idx_d = idx_q + c_TWO;
                    if (idx_q + c_TWO >= c_SIZE) begin
                        state_d = S_FIN;
                        done_d  = 1'b1;
                    end else if (abort_now) begin
                        state_d   = S_FIN;
                        done_d    = 1'b1;
                        aborted_d = 1'b1;
                    end else begin
                        state_d = S_FETCH;
                    end
                end else if (abort && !dump_last_q) begin
                    abort_lat_d = 1'b1;
                end
            end
            S_FIN: begin
                state_d     = S_IDLE;
                idx_d       = '0;
                abort_lat_d = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they come straight off flops.
        nxt_d        = idx_d + c_ONE;
        beat_idx     = (state_d == S_SEND1) ? nxt_d : idx_d;
        busy_d       = (state_d != S_IDLE);
        hold_req_d   = busy_d;  // held through FIN; released on return to IDLE
        rd_sel_d     = (state_d == S_FETCH);
        rd_src1_d    = rd_sel_d ? idx_d[p_REG_ADDR_LEN-1:0] : '0;
        rd_src2_d    = (rd_sel_d && (nxt_d < c_SIZE)) ? nxt_d[p_REG_ADDR_LEN-1:0] : '0;
        dump_valid_d = (state_d == S_SEND0) || (state_d == S_SEND1);
        dump_data_d  = (state_d == S_SEND0) ? buf0_d :
                       (state_d == S_SEND1) ? buf1_d : '0;
        dump_addr_d  = dump_valid_d ? beat_idx[p_REG_ADDR_LEN-1:0] : '0;
        dump_last_d  = dump_valid_d && (beat_idx == c_LAST);
    end

    // NOTE: state flops use non-blocking assignments; the comb block above uses blocking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            buf0_q       <= '0;
            buf1_q       <= '0;
            buf1_vld_q   <= 1'b0;
            abort_lat_q  <= 1'b0;
            hold_req_q   <= 1'b0;
            rd_sel_q     <= 1'b0;
            rd_src1_q    <= '0;
            rd_src2_q    <= '0;
            dump_valid_q <= 1'b0;
            dump_data_q  <= '0;
            dump_addr_q  <= '0;
            dump_last_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            buf0_q       <= buf0_d;
            buf1_q       <= buf1_d;
            buf1_vld_q   <= buf1_vld_d;
            abort_lat_q  <= abort_lat_d;
            hold_req_q   <= hold_req_d;
            rd_sel_q     <= rd_sel_d;
            rd_src1_q    <= rd_src1_d;
            rd_src2_q    <= rd_src2_d;
            dump_valid_q <= dump_valid_d;
            dump_data_q  <= dump_data_d;
            dump_addr_q  <= dump_addr_d;
            dump_last_q  <= dump_last_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
        end
    end

    assign hold_req   = hold_req_q;
    assign rd_sel     = rd_sel_q;
    assign rd_src1    = rd_src1_q;
    assign rd_src2    = rd_src2_q;
    assign dump_valid = dump_valid_q;
    assign dump_data  = dump_data_q;
    assign dump_addr  = dump_addr_q;
    assign dump_last  = dump_last_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign aborted    = aborted_q;

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Scoreboard bench for regfile_dump_ctrl: an 8-entry and a 7-entry instance
// read from a behavioural register file holding R[i] = 0x1111*i.
module tb_regfile_dump_ctrl;

    typedef struct packed {
        logic [2:0]  addr;
        logic [15:0] data;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n;
    logic start8, start7, abort, hold_ack, dump_ready;

    logic        h8, sel8, v8, l8, busy8, done8, ab8;
    logic [2:0]  src1_8, src2_8, a8;
    logic [15:0] out1_8, out2_8, d8;
    logic        h7, sel7_o, v7, l7, busy7, done7, ab7;
    logic [2:0]  src1_7, src2_7, a7;
    logic [15:0] out1_7, out2_7, d7;

    int    checks   = 0;
    int    failures = 0;
    int    beats    = 0;
    int    cyc      = 0;
    bit    sel7     = 1'b0;
    bit    mon_en   = 1'b1;
    beat_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] rv(input logic [2:0] a);
        return 16'(a) * 16'h1111;
    endfunction

    assign out1_8 = rv(src1_8);
    assign out2_8 = rv(src2_8);
    assign out1_7 = rv(src1_7);
    assign out2_7 = rv(src2_7);

    regfile_dump_ctrl #(.p_WORD_LEN(16), .p_REG_ADDR_LEN(3), .p_REG_FILE_SIZE(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .abort(abort),
        .hold_req(h8), .hold_ack(hold_ack), .rd_src1(src1_8), .rd_src2(src2_8),
        .rd_out1(out1_8), .rd_out2(out2_8), .rd_sel(sel8), .dump_valid(v8),
        .dump_ready(dump_ready), .dump_data(d8), .dump_addr(a8), .dump_last(l8),
        .busy(busy8), .done(done8), .aborted(ab8)
    );

    regfile_dump_ctrl #(.p_WORD_LEN(16), .p_REG_ADDR_LEN(3), .p_REG_FILE_SIZE(7)) dut7 (
        .clk(clk), .rst_n(rst_n), .start(start7), .abort(abort),
        .hold_req(h7), .hold_ack(hold_ack), .rd_src1(src1_7), .rd_src2(src2_7),
        .rd_out1(out1_7), .rd_out2(out2_7), .rd_sel(sel7_o), .dump_valid(v7),
        .dump_ready(dump_ready), .dump_data(d7), .dump_addr(a7), .dump_last(l7),
        .busy(busy7), .done(done7), .aborted(ab7)
    );

    // Stream monitor: pops the scoreboard on each handshake and checks stalled beats stay put.
    initial begin
        beat_t cur, exp_b, snap;
        bit    stalled_m;
        logic  mv;
        stalled_m = 1'b0;
        snap      = '0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                stalled_m = 1'b0;
            end else begin
                mv       = sel7 ? v7 : v8;
                cur.addr = sel7 ? a7 : a8;
                cur.data = sel7 ? d7 : d8;
                cur.last = sel7 ? l7 : l8;
                if (stalled_m) begin
                    checks++;
                    if (!mv || cur !== snap) begin
                        $display("FAIL stream_hold got valid=%b beat=%h exp beat=%h", mv, cur, snap);
                        failures++;
                    end
                end
                stalled_m = 1'b0;
                if (mv) begin
                    if (dump_ready) begin
                        checks++;
                        beats++;
                        if (exp_q.size() == 0) begin
                            $display("FAIL unexpected_beat got=%h exp=none", cur);
                            failures++;
                        end else begin
                            exp_b = exp_q.pop_front();
                            if (cur !== exp_b) begin
                                $display("FAIL beat got=%h exp=%h", cur, exp_b);
                                failures++;
                            end
                        end
                    end else begin
                        stalled_m = 1'b1;
                        snap      = cur;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int n, input int size);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.addr = 3'(i);
            b.data = 16'(i) * 16'h1111;
            b.last = (i == size - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic start_dump(output int c0, input logic ack);
        tick();
        if (sel7) start7 = 1'b1;
        else      start8 = 1'b1;
        c0 = cyc;
        tick();
        start7   = 1'b0;
        start8   = 1'b0;
        hold_ack = ack;
    endtask

    // mode 0: ready tied high; mode 1: random ready with a 5-cycle stall on addr 3.
    task automatic wait_done(input int budget, input int mode, output bit got,
                             output int dcyc, output logic ab);
        int hold_cnt = 0;
        bit held     = 1'b0;
        got  = 1'b0;
        dcyc = 0;
        ab   = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            tick();
            if (mode == 1) begin
                if (!held && v8 && a8 == 3'd3) begin
                    held     = 1'b1;
                    hold_cnt = 5;
                end
                if (hold_cnt > 0) begin
                    dump_ready = 1'b0;
                    hold_cnt--;
                end else begin
                    dump_ready = 1'($urandom_range(0, 1));
                end
            end else begin
                dump_ready = 1'b1;
            end
            @(negedge clk);
            if (sel7 ? done7 : done8) begin
                got  = 1'b1;
                dcyc = cyc;
                ab   = sel7 ? ab7 : ab8;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({h8, sel8, src1_8, src2_8, busy8, done8, ab8} !== '0) begin
            $display("FAIL reset_ctrl8 got=%b exp=0", {h8, sel8, src1_8, src2_8, busy8, done8, ab8});
            failures++;
        end
        checks++;
        if ({v8, d8, a8, l8} !== '0) begin
            $display("FAIL reset_stream8 got=%h exp=0", {v8, d8, a8, l8});
            failures++;
        end
        checks++;
        if ({h7, sel7_o, src1_7, src2_7, busy7, done7, ab7, v7, d7, a7, l7} !== '0) begin
            $display("FAIL reset_dut7 got=%h exp=0",
                     {h7, sel7_o, src1_7, src2_7, busy7, done7, ab7, v7, d7, a7, l7});
            failures++;
        end
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy8, h8, busy7, h7} !== 4'b0) begin
            $display("FAIL idle_after_reset got=%b exp=0000", {busy8, h8, busy7, h7});
            failures++;
        end
    endtask

    task automatic test_full_dump();
        int c0, dc, b0;
        bit got;
        logic ab;
        push_exp(8, 8);
        b0 = beats;
        start_dump(c0, 1'b1);
        wait_done(40, 0, got, dc, ab);
        checks++;
        if (!got) begin $display("FAIL full_done_timeout got=0 exp=1"); failures++; end
        checks++;
        if (dc - c0 != 14) begin $display("FAIL full_latency got=%0d exp=14", dc - c0); failures++; end
        checks++;
        if (ab !== 1'b0) begin $display("FAIL full_aborted got=%b exp=0", ab); failures++; end
        checks++;
        if (beats - b0 != 8) begin $display("FAIL full_beats got=%0d exp=8", beats - b0); failures++; end
        checks++;
        if (exp_q.size() != 0) begin $display("FAIL full_leftover got=%0d exp=0", exp_q.size()); failures++; end
        exp_q.delete();
        @(negedge clk);
        checks++;
        if ({done8, h8, busy8} !== 3'b0) begin
            $display("FAIL full_after_fin got=%b exp=000", {done8, h8, busy8});
            failures++;
        end
        hold_ack = 1'b0;
    endtask

    task automatic test_random_ready();
        int c0, dc, b0;
        bit got;
        logic ab;
        push_exp(8, 8);
        b0 = beats;
        start_dump(c0, 1'b1);
        wait_done(300, 1, got, dc, ab);
        dump_ready = 1'b1;
        checks++;
        if (!got) begin $display("FAIL rand_done_timeout got=0 exp=1"); failures++; end
        checks++;
        if (beats - b0 != 8) begin $display("FAIL rand_beats got=%0d exp=8", beats - b0); failures++; end
        checks++;
        if (exp_q.size() != 0 || ab !== 1'b0) begin
            $display("FAIL rand_end got leftover=%0d aborted=%b exp 0/0", exp_q.size(), ab);
            failures++;
        end
        exp_q.delete();
        hold_ack = 1'b0;
    endtask

    task automatic test_hold_wait();
        int c0, dc, b0;
        bit got;
        logic ab;
        push_exp(8, 8);
        b0 = beats;
        start_dump(c0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if ({h8, sel8, v8} !== 3'b100) begin
                $display("FAIL hold_wait cycle=%0d got={hold_req,rd_sel,valid}=%b exp=100", i, {h8, sel8, v8});
                failures++;
            end
        end
        tick();
        hold_ack = 1'b1;
        wait_done(60, 0, got, dc, ab);
        checks++;
        if (!got || dc - c0 != 24) begin
            $display("FAIL hold_wait_latency got=%0d exp=24 (done=%b)", dc - c0, got);
            failures++;
        end
        checks++;
        if (beats - b0 != 8 || ab !== 1'b0) begin
            $display("FAIL hold_wait_beats got=%0d aborted=%b exp 8/0", beats - b0, ab);
            failures++;
        end
        exp_q.delete();
        hold_ack = 1'b0;
    endtask

    task automatic test_abort_hold();
        int c0, dc, b0;
        bit got;
        logic ab;
        b0 = beats;
        start_dump(c0, 1'b0);
        tick();
        abort = 1'b1;
        wait_done(5, 0, got, dc, ab);
        abort = 1'b0;
        checks++;
        if (!got || dc - c0 != 3) begin
            $display("FAIL abort_hold_done got=%0d exp=3 (done=%b)", dc - c0, got);
            failures++;
        end
        checks++;
        if (ab !== 1'b1) begin $display("FAIL abort_hold_aborted got=%b exp=1", ab); failures++; end
        checks++;
        if ({h8, busy8} !== 2'b00 || beats != b0) begin
            $display("FAIL abort_hold_idle got hold/busy=%b beats=%0d exp 00/0", {h8, busy8}, beats - b0);
            failures++;
        end
    endtask

    task automatic test_abort_pending();
        int c0, b0, cnt;
        bit got, stalled;
        logic ab;
        push_exp(3, 8);
        b0      = beats;
        got     = 1'b0;
        stalled = 1'b0;
        cnt     = 0;
        ab      = 1'b0;
        start_dump(c0, 1'b1);
        for (int i = 0; i < 60 && !got; i++) begin
            tick();
            if (!stalled && v8 && a8 == 3'd2) stalled = 1'b1;
            if (stalled) begin
                cnt++;
                abort      = 1'b1;
                dump_ready = (cnt > 3);
            end else begin
                dump_ready = 1'b1;
            end
            @(negedge clk);
            if (done8) begin
                got = 1'b1;
                ab  = ab8;
            end
        end
        abort      = 1'b0;
        dump_ready = 1'b1;
        checks++;
        if (!got || ab !== 1'b1) begin
            $display("FAIL abort_pend_done got done=%b aborted=%b exp 1/1", got, ab);
            failures++;
        end
        checks++;
        if (beats - b0 != 3 || exp_q.size() != 0) begin
            $display("FAIL abort_pend_beats got=%0d leftover=%0d exp 3/0", beats - b0, exp_q.size());
            failures++;
        end
        exp_q.delete();
        @(negedge clk);
        checks++;
        if ({h8, busy8, done8} !== 3'b000) begin
            $display("FAIL abort_pend_release got=%b exp=000", {h8, busy8, done8});
            failures++;
        end
        hold_ack = 1'b0;
    endtask

    task automatic test_size7();
        int c0, dc, b0, fetch_n;
        bit got;
        logic ab;
        logic [2:0] exp2;
        sel7    = 1'b1;
        fetch_n = 0;
        got     = 1'b0;
        dc      = 0;
        ab      = 1'b0;
        push_exp(7, 7);
        b0 = beats;
        start_dump(c0, 1'b1);
        for (int i = 0; i < 40 && !got; i++) begin
            tick();
            dump_ready = 1'b1;
            @(negedge clk);
            if (sel7_o) begin
                exp2 = (src1_7 == 3'd6) ? 3'd0 : src1_7 + 3'd1;
                checks++;
                if (src1_7 !== 3'(2 * fetch_n) || src2_7 !== exp2) begin
                    $display("FAIL size7_fetch got src1=%0d src2=%0d exp src1=%0d src2=%0d",
                             src1_7, src2_7, 2 * fetch_n, exp2);
                    failures++;
                end
                fetch_n++;
            end
            if (done7) begin
                got = 1'b1;
                dc  = cyc;
                ab  = ab7;
            end
        end
        checks++;
        if (!got || dc - c0 != 13 || ab !== 1'b0) begin
            $display("FAIL size7_done got lat=%0d aborted=%b exp 13/0 (done=%b)", dc - c0, ab, got);
            failures++;
        end
        checks++;
        if (beats - b0 != 7 || fetch_n != 4 || exp_q.size() != 0) begin
            $display("FAIL size7_count got beats=%0d fetches=%0d exp 7/4", beats - b0, fetch_n);
            failures++;
        end
        exp_q.delete();
        @(negedge clk);
        sel7     = 1'b0;
        hold_ack = 1'b0;
    endtask

    task automatic test_reset_mid();
        int c0, dc, b0;
        bit got, found;
        logic ab;
        found = 1'b0;
        push_exp(8, 8);
        start_dump(c0, 1'b1);
        for (int i = 0; i < 30 && !found; i++) begin
            tick();
            dump_ready = 1'b1;
            if (v8 && a8 == 3'd3) found = 1'b1;
        end
        mon_en = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (!found || {v8, h8, busy8} !== 3'b000) begin
            $display("FAIL reset_mid got found=%b valid/hold/busy=%b exp 1/000", found, {v8, h8, busy8});
            failures++;
        end
        exp_q.delete();
        hold_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (done8 !== 1'b0) begin $display("FAIL reset_mid_done got=%b exp=0", done8); failures++; end
        end
        tick();
        rst_n  = 1'b1;
        mon_en = 1'b1;
        push_exp(8, 8);
        b0 = beats;
        start_dump(c0, 1'b1);
        wait_done(40, 0, got, dc, ab);
        checks++;
        if (!got || dc - c0 != 14 || ab !== 1'b0) begin
            $display("FAIL redump_done got lat=%0d aborted=%b exp 14/0 (done=%b)", dc - c0, ab, got);
            failures++;
        end
        checks++;
        if (beats - b0 != 8 || exp_q.size() != 0) begin
            $display("FAIL redump_beats got=%0d exp=8", beats - b0);
            failures++;
        end
        exp_q.delete();
        hold_ack = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        start8     = 1'b0;
        start7     = 1'b0;
        abort      = 1'b0;
        hold_ack   = 1'b0;
        dump_ready = 1'b0;
        test_reset();
        test_full_dump();
        test_random_ready();
        test_hold_wait();
        test_abort_hold();
        test_abort_pending();
        test_size7();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
